// File: rtl/fuzzycpu_pkg.sv
// fuzzycpu_pkg: shared register-file widths and the writeback entry type
package fuzzycpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: finds the youngest stored queue entry whose address matches a lookup address
module wb_fwd_match
    import fuzzycpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic [PW-1:0]         head,
    input  logic [DEPTH-1:0]      valid,
    input  wb_entry_t             entries [DEPTH],
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [REG_DATA_W-1:0] val
);
    logic [PW-1:0] idx;
    // walk from oldest to youngest so the last match seen is the youngest one
    always_comb begin
        hit = 1'b0;
        val = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && entries[idx].addr == addr) begin
                hit = 1'b1;
                val = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result queue from ALU/MDU to the register-file write port with operand forwarding
module writeback_queue
    import fuzzycpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_ADDR_W-1:0]        alu_addr,
    input  logic [REG_DATA_W-1:0]        alu_data,
    input  logic                         mdu_valid,
    output logic                         mdu_ready,
    input  logic [REG_ADDR_W-1:0]        mdu_addr,
    input  logic [REG_DATA_W-1:0]        mdu_data,
    input  logic                         wb_hold,
    output logic                         wr_enb,
    output logic [REG_ADDR_W-1:0]        wr_addr,
    output logic [REG_DATA_W-1:0]        wr_data,
    input  logic [REG_ADDR_W-1:0]        fwd_addr_1,
    input  logic [REG_ADDR_W-1:0]        fwd_addr_2,
    output logic                         fwd_hit_1,
    output logic                         fwd_hit_2,
    output logic [REG_DATA_W-1:0]        fwd_val_1,
    output logic [REG_DATA_W-1:0]        fwd_val_2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    wb_entry_t      mem [DEPTH];
    wb_entry_t      in_e;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]  head, tail;
    logic           full, enq, deq;
    // handshake, source select and head presentation; readies are forced low while in reset
    always_comb begin
        full      = count == CW'(DEPTH);
        alu_ready = rst_n && !full;
        mdu_ready = rst_n && !full && !alu_valid;
        in_e.addr = alu_valid ? alu_addr : mdu_addr;
        in_e.data = alu_valid ? alu_data : mdu_data;
        enq       = ((alu_valid && alu_ready) || (mdu_valid && mdu_ready)) && !(DROP_R0 && in_e.addr == '0);
        wr_enb    = count != '0 && !wb_hold;
        deq       = wr_enb;
        wr_addr   = count != '0 ? mem[head].addr : '0;
        wr_data   = count != '0 ? mem[head].data : '0;
    end
    // pointer, occupancy and per-entry valid bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (enq) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (deq) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end
    // entry payload storage; validity alone decides whether an entry is live
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= in_e;
    end
    wb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd_1 (
        .head(head), .valid(valid), .entries(mem), .addr(fwd_addr_1), .hit(fwd_hit_1), .val(fwd_val_1)
    );
    wb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd_2 (
        .head(head), .valid(valid), .entries(mem), .addr(fwd_addr_2), .hit(fwd_hit_2), .val(fwd_val_2)
    );
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and random checks of writeback_queue against a queue-based model
module tb_writeback_queue;
    localparam int DEPTH = 4;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mdu_valid = 1'b0, wb_hold = 1'b0;
    logic [4:0]  alu_addr = '0, mdu_addr = '0, fwd_addr_1 = '0, fwd_addr_2 = '0;
    logic [31:0] alu_data = '0, mdu_data = '0;
    logic        alu_ready, mdu_ready, wr_enb, fwd_hit_1, fwd_hit_2;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, fwd_val_1, fwd_val_2;
    logic [2:0]  count;
    ent_t        q[$];
    int          n_chk = 0, n_fail = 0;
    logic        last_acc_a = 1'b0, last_acc_m = 1'b0;

    writeback_queue #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .wb_hold(wb_hold), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_val_1(fwd_val_1), .fwd_val_2(fwd_val_2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic h);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        wb_hold = h;
    endtask

    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        foreach (q[i]) if (q[i].a == a) begin
            hit = 1'b1;
            val = q[i].d;
        end
    endtask

    task automatic compare_model();
        int sz;
        logic h;
        logic [31:0] v;
        sz = q.size();
        chk("alu_ready", alu_ready, sz < DEPTH);
        chk("mdu_ready", mdu_ready, sz < DEPTH && !alu_valid);
        chk("wr_enb", wr_enb, sz != 0 && !wb_hold);
        chk("wr_addr", wr_addr, sz != 0 ? q[0].a : 5'd0);
        chk("wr_data", wr_data, sz != 0 ? q[0].d : 32'd0);
        chk("count", count, sz);
        model_fwd(fwd_addr_1, h, v);
        chk("fwd_hit_1", fwd_hit_1, h);
        chk("fwd_val_1", fwd_val_1, v);
        model_fwd(fwd_addr_2, h, v);
        chk("fwd_hit_2", fwd_hit_2, h);
        chk("fwd_val_2", fwd_val_2, v);
    endtask

    task automatic step();
        int   sz;
        logic deq, aa, am, push;
        ent_t ne;
        compare_model();
        sz   = q.size();
        deq  = sz != 0 && !wb_hold;
        aa   = alu_valid && sz < DEPTH;
        am   = mdu_valid && sz < DEPTH && !alu_valid;
        ne.a = aa ? alu_addr : mdu_addr;
        ne.d = aa ? alu_data : mdu_data;
        push = (aa || am) && ne.a != 5'd0;
        last_acc_a = aa;
        last_acc_m = am;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (push) q.push_back(ne);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 5'd5, 32'h9, 1'b1, 5'd6, 32'h7, 1'b0);
        fwd_addr_1 = 5'd5;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mdu_ready", mdu_ready, 0);
        chk("rst_wr_enb", wr_enb, 0);
        chk("rst_count", count, 0);
        chk("rst_fwd_hit_1", fwd_hit_1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r40_alu_ready", alu_ready, 1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r40_wr_enb", wr_enb, 1);
        chk("r40_wr_addr", wr_addr, 5);
        chk("r40_wr_data", wr_data, 32'h9);
        chk("r40_fwd", fwd_val_1, 32'h9);
        step();
        #1;
        chk("r40_count_after", count, 0);
        chk("r40_wr_enb_after", wr_enb, 0);

        drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0);
        #1;
        chk("r41_mdu_blocked", mdu_ready, 0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hB, 1'b0);
        #1;
        chk("r41_first_addr", wr_addr, 1);
        chk("r41_first_data", wr_data, 32'hA);
        chk("r41_mdu_ready", mdu_ready, 1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r41_second_addr", wr_addr, 2);
        chk("r41_second_data", wr_data, 32'hB);
        step();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'h100 + i, 1'b0, 5'd0, 32'h0, 1'b1);
            #1;
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        chk("r42_count_full", count, 4);
        chk("r42_alu_ready_full", alu_ready, 0);
        chk("r42_mdu_ready_full", mdu_ready, 0);
        step();
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r42_order_addr", wr_addr, 10 + i);
            chk("r42_order_data", wr_data, 32'h100 + i);
            chk("r42_alu_ready", alu_ready, i != 0);
            step();
        end
        #1;
        chk("r42_drained", count, 0);

        drive(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        step();
        drive(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        fwd_addr_1 = 5'd3;
        fwd_addr_2 = 5'd4;
        #1;
        chk("r43_hit_1", fwd_hit_1, 1);
        chk("r43_val_1", fwd_val_1, 32'h2);
        chk("r43_hit_2", fwd_hit_2, 0);
        chk("r43_val_2", fwd_val_2, 0);
        step();
        wb_hold = 1'b0;
        #1;
        chk("r43_head_hit", fwd_hit_1, 1);
        repeat (3) step();

        drive(1'b1, 5'd0, 32'hFFFF_FFFD, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r44_alu_ready", alu_ready, 1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r44_count", count, 0);
        chk("r44_wr_enb", wr_enb, 0);
        step();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(7 + i), 32'hC0 + i, 1'b0, 5'd0, 32'h0, 1'b1);
            #1;
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        fwd_addr_1 = 5'd8;
        #1;
        chk("r45_pre_hit", fwd_hit_1, 1);
        chk("r45_pre_count", count, 3);
        rst_n = 1'b0;
        #1;
        chk("r45_alu_ready", alu_ready, 0);
        chk("r45_mdu_ready", mdu_ready, 0);
        chk("r45_count", count, 0);
        chk("r45_wr_enb", wr_enb, 0);
        chk("r45_wr_addr", wr_addr, 0);
        chk("r45_wr_data", wr_data, 0);
        chk("r45_fwd_hit", fwd_hit_1, 0);
        chk("r45_fwd_val", fwd_val_1, 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r45_no_write", wr_enb, 0);
            step();
        end

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        last_acc_a = 1'b0;
        last_acc_m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!alu_valid || last_acc_a) begin
                alu_valid = $urandom_range(0, 1) == 1;
                alu_addr  = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!mdu_valid || last_acc_m) begin
                mdu_valid = $urandom_range(0, 2) == 0;
                mdu_addr  = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            wb_hold    = $urandom_range(0, 3) == 0;
            fwd_addr_1 = 5'($urandom_range(0, 7));
            fwd_addr_2 = 5'($urandom_range(0, 7));
            #1;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
